// File: rtl/l1_fill_buffer_if.sv
// Fill-buffer bus bundle: request handshake, memory beat stream,
// data-array write port and status/critical-word outputs.
interface l1_fill_buffer_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BEAT_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_idx_i;
    logic [1:0]            req_word_i;
    logic                  mem_valid_i;
    logic                  mem_ready_o;
    logic [BEAT_WIDTH-1:0] mem_data_i;
    logic                  dat_we_o;
    logic [15:0]           dat_be_o;
    logic [ADDR_WIDTH-1:0] dat_addr_o;
    logic [DATA_WIDTH-1:0] dat_data_o;
    logic                  crit_valid_o;
    logic [BEAT_WIDTH-1:0] crit_data_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output req_valid_i, req_idx_i, req_word_i, mem_valid_i, mem_data_i,
        input  req_ready_o, mem_ready_o, dat_we_o, dat_be_o, dat_addr_o,
               dat_data_o, crit_valid_o, crit_data_o, busy_o, done_o
    );

    modport slave (
        input  req_valid_i, req_idx_i, req_word_i, mem_valid_i, mem_data_i,
        output req_ready_o, mem_ready_o, dat_we_o, dat_be_o, dat_addr_o,
               dat_data_o, crit_valid_o, crit_data_o, busy_o, done_o
    );
endinterface

// File: rtl/l1_fill_buffer.sv
// L1 line fill buffer: collects four memory beats into a line and writes
// it to the data array in one cycle.
// Optional feature macro: L1_FILL_CRIT_WORD_EN (critical-word-first fill
// starting at the requested word, with a one-cycle critical-word pulse).
module l1_fill_buffer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BEAT_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    l1_fill_buffer_if.slave   bus
);
    localparam int unsigned NUM_BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned BE_WIDTH  = 16;

`ifdef L1_FILL_CRIT_WORD_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            word_q, word_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic [1:0]            slot_c;

    logic                  dat_we_q;
    logic [BE_WIDTH-1:0]   dat_be_q;
    logic [ADDR_WIDTH-1:0] dat_addr_q;
    logic [DATA_WIDTH-1:0] dat_data_q;
    logic                  busy_q;
    logic                  done_q;

    // Handshake readies decoded straight from state
    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.mem_ready_o = (state_q == FILL);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state, request latch and beat placement into the line
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        line_d  = line_q;
        slot_c  = (CRIT_EN ? word_q : 2'd0) + cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    idx_d   = bus.req_idx_i;
                    word_d  = bus.req_word_i;
                    cnt_d   = 2'd0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.mem_valid_i) begin
                    for (int unsigned k = 0; k < NUM_BEATS; k++) begin
                        if (slot_c == 2'(k)) line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_data_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill context: beat counter, latched request and partial line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            idx_q  <= '0;
            word_q <= 2'd0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            word_q <= word_d;
            line_q <= line_d;
        end
    end

    // Registered array write port and status, timed off the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_we_q   <= 1'b0;
            dat_be_q   <= '0;
            dat_addr_q <= '0;
            dat_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dat_we_q <= (state_d == WRITE);
            done_q   <= (state_d == WRITE);
            busy_q   <= (state_d != IDLE);
            dat_be_q <= (state_d == WRITE) ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
            if (state_d == WRITE) begin
                dat_addr_q <= idx_q;
                dat_data_q <= line_d;
            end
        end
    end

    assign bus.dat_we_o   = dat_we_q;
    assign bus.dat_be_o   = dat_be_q;
    assign bus.dat_addr_o = dat_addr_q;
    assign bus.dat_data_o = dat_data_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

`ifdef L1_FILL_CRIT_WORD_EN
    logic                  crit_fire_c;
    logic                  crit_valid_q;
    logic [BEAT_WIDTH-1:0] crit_data_q;

    assign crit_fire_c = (state_q == FILL) && bus.mem_valid_i && (cnt_q == 2'd0);

    // Critical word: first accepted beat, presented for one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= crit_fire_c;
            if (crit_fire_c) crit_data_q <= bus.mem_data_i;
        end
    end

    assign bus.crit_valid_o = crit_valid_q;
    assign bus.crit_data_o  = crit_data_q;
`else
    assign bus.crit_valid_o = 1'b0;
    assign bus.crit_data_o  = '0;
`endif
endmodule

// File: tb/tb_l1_fill_buffer.sv
// Directed bench for l1_fill_buffer with a scoreboard of expected line writes.
module tb_l1_fill_buffer;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 6;
    localparam int unsigned BW = 32;

`ifdef L1_FILL_CRIT_WORD_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    typedef logic [BW-1:0] beats_t [4];
    typedef int            gaps_t  [4];
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_wr   = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    wr_t  sb[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    l1_fill_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) bus ();

    l1_fill_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_line(input beats_t b, input logic [1:0] start);
        logic [DW-1:0] l = '0;
        logic [1:0]    s;
        for (int i = 0; i < 4; i++) begin
            s = start + 2'(i);
            l[int'(s)*BW +: BW] = b[i];
        end
        return l;
    endfunction

    // Scoreboard consumer: every array write must match the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni && bus.dat_we_o === 1'b1) begin
            n_wr++;
            chk("write_expected", DW'(sb.size() != 0), DW'(1'b1));
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", DW'(bus.dat_addr_o), DW'(e.addr));
                chk("wr_data", bus.dat_data_o, e.data);
                chk("wr_be", DW'(bus.dat_be_o), DW'(16'hFFFF));
                chk("wr_done", DW'(bus.done_o), DW'(1'b1));
            end
        end
    end

    task automatic accept(input logic [AW-1:0] idx, input logic [1:0] word, input bit hold);
        int w = 0;
        bus.req_idx_i   = idx;
        bus.req_word_i  = word;
        bus.req_valid_i = 1'b1;
        while (bus.req_ready_o !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_wait", DW'(bus.req_ready_o), DW'(1'b1));
        tick();
        acc_cyc = cyc;
        if (!hold) bus.req_valid_i = 1'b0;
        chk("acc_busy", DW'(bus.busy_o), DW'(1'b1));
        chk("acc_req_ready", DW'(bus.req_ready_o), DW'(1'b0));
        chk("acc_mem_ready", DW'(bus.mem_ready_o), DW'(1'b1));
    endtask

    task automatic send_beats(input beats_t b, input gaps_t g, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < g[i]; k++) begin
                bus.mem_valid_i = 1'b0;
                tick();
                chk("gap_busy", DW'(bus.busy_o), DW'(1'b1));
                chk("gap_mem_ready", DW'(bus.mem_ready_o), DW'(1'b1));
            end
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = b[i];
            chk("beat_mem_ready", DW'(bus.mem_ready_o), DW'(1'b1));
            tick();
            bus.mem_valid_i = 1'b0;
            if (i == 0) begin
                chk("crit_valid", DW'(bus.crit_valid_o), DW'(CRIT));
                chk("crit_data", DW'(bus.crit_data_o), CRIT ? DW'(b[0]) : DW'(0));
            end
            if (i == 1) chk("crit_pulse_end", DW'(bus.crit_valid_o), DW'(1'b0));
        end
    endtask

    task automatic full_fill(input logic [AW-1:0] idx, input logic [1:0] word, input beats_t b,
                             input gaps_t g, input int lat, input bit hold,
                             input logic [AW-1:0] idx_after);
        wr_t e;
        e.addr = idx;
        e.data = mk_line(b, CRIT ? word : 2'd0);
        sb.push_back(e);
        accept(idx, word, hold);
        if (hold) bus.req_idx_i = idx_after;
        send_beats(b, g, 4);
        chk("latency", DW'(cyc - acc_cyc + 1), DW'(lat));
        chk("wr_we", DW'(bus.dat_we_o), DW'(1'b1));
        chk("wr_busy", DW'(bus.busy_o), DW'(1'b1));
        chk("wr_req_ready", DW'(bus.req_ready_o), DW'(1'b0));
        chk("wr_mem_ready", DW'(bus.mem_ready_o), DW'(1'b0));
        if (hold) begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = 32'hDEADBEEF;
        end
        tick();
        bus.mem_valid_i = 1'b0;
        chk("post_we", DW'(bus.dat_we_o), DW'(1'b0));
        chk("post_be", DW'(bus.dat_be_o), DW'(16'h0000));
        chk("post_done", DW'(bus.done_o), DW'(1'b0));
        chk("post_busy", DW'(bus.busy_o), DW'(1'b0));
        chk("post_req_ready", DW'(bus.req_ready_o), DW'(1'b1));
        chk("hold_addr", DW'(bus.dat_addr_o), DW'(e.addr));
        chk("hold_data", bus.dat_data_o, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        beats_t b20, babcd, bsp;
        gaps_t  g0, g22;
        logic [DW-1:0] exp21;
        b20   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        babcd = '{32'hAAAA000A, 32'hBBBB000B, 32'hCCCC000C, 32'hDDDD000D};
        bsp   = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
        g0    = '{0, 0, 0, 0};
        g22   = '{0, 3, 0, 3};

        bus.req_valid_i = 1'b0;
        bus.req_idx_i   = '0;
        bus.req_word_i  = 2'd0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;

        // Reset state
        #12;
        chk("rst_we", DW'(bus.dat_we_o), DW'(1'b0));
        chk("rst_be", DW'(bus.dat_be_o), DW'(16'h0000));
        chk("rst_addr", DW'(bus.dat_addr_o), DW'(0));
        chk("rst_data", bus.dat_data_o, DW'(0));
        chk("rst_crit_valid", DW'(bus.crit_valid_o), DW'(1'b0));
        chk("rst_crit_data", DW'(bus.crit_data_o), DW'(0));
        chk("rst_busy", DW'(bus.busy_o), DW'(1'b0));
        chk("rst_done", DW'(bus.done_o), DW'(1'b0));
        chk("rst_req_ready", DW'(bus.req_ready_o), DW'(1'b1));
        chk("rst_mem_ready", DW'(bus.mem_ready_o), DW'(1'b0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        tick();

        // Basic in-order fill, back-to-back beats
        full_fill(6'h2A, 2'd0, b20, g0, 5, 1'b0, 6'h00);
        chk("r20_line", bus.dat_data_o, 128'h44444444_33333333_22222222_11111111);

        // Word 2 request: rotated fill with the feature on, in-order otherwise
        full_fill(6'h15, 2'd2, babcd, g0, 5, 1'b0, 6'h00);
        exp21 = CRIT ? 128'hBBBB000B_AAAA000A_DDDD000D_CCCC000C
                     : 128'hDDDD000D_CCCC000C_BBBB000B_AAAA000A;
        chk("r21_line", bus.dat_data_o, exp21);

        // Stalled beats
        full_fill(6'h2A, 2'd0, b20, g22, 11, 1'b0, 6'h00);
        chk("r22_line", bus.dat_data_o, 128'h44444444_33333333_22222222_11111111);

        // Spurious memory beats in IDLE are ignored
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_mem_ready", DW'(bus.mem_ready_o), DW'(1'b0));
            chk("idle_busy", DW'(bus.busy_o), DW'(1'b0));
        end
        bus.mem_valid_i = 1'b0;

        // Request held through a fill; second one taken only after done
        full_fill(6'h11, 2'd0, bsp, g0, 5, 1'b1, 6'h22);
        full_fill(6'h22, 2'd1, b20, g0, 5, 1'b0, 6'h00);

        // Reset mid-fill abandons the line
        accept(6'h05, 2'd0, 1'b0);
        send_beats(babcd, g0, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_we", DW'(bus.dat_we_o), DW'(1'b0));
        chk("mid_rst_busy", DW'(bus.busy_o), DW'(1'b0));
        chk("mid_rst_addr", DW'(bus.dat_addr_o), DW'(0));
        chk("mid_rst_data", bus.dat_data_o, DW'(0));
        chk("mid_rst_req_ready", DW'(bus.req_ready_o), DW'(1'b1));
        chk("mid_rst_mem_ready", DW'(bus.mem_ready_o), DW'(1'b0));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("rel_busy", DW'(bus.busy_o), DW'(1'b0));
        chk("rel_we", DW'(bus.dat_we_o), DW'(1'b0));
        full_fill(6'h05, 2'd0, babcd, g0, 5, 1'b0, 6'h00);

        // Top index, last word
        full_fill(6'h3F, 2'd3, bsp, g0, 5, 1'b0, 6'h00);

        repeat (3) tick();
        chk("sb_empty", DW'(sb.size()), DW'(0));
        chk("write_count", DW'(n_wr), DW'(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/l1_fill_buffer.md
L1_FILL_BUFFER -- requirements
Module: l1_fill_buffer

Interface
REQ-001 The block SHALL have parameters DATA_WIDTH, default 128, line width in bits; ADDR_WIDTH, default 6, set index width; BEAT_WIDTH, default 32, memory beat width (DATA_WIDTH/BEAT_WIDTH = 4 beats).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  fill request valid
- req_ready_o  output  1  fill request accept
- req_idx_i  input  ADDR_WIDTH  set index of line to fill
- req_word_i  input  2  word offset of the missing access
- mem_valid_i  input  1  memory beat valid
- mem_ready_o  output  1  memory beat accept
- mem_data_i  input  BEAT_WIDTH  memory beat data
- dat_we_o  output  1  data-array write enable
- dat_be_o  output  16  data-array byte enable
- dat_addr_o  output  ADDR_WIDTH  data-array index
- dat_data_o  output  DATA_WIDTH  data-array write line
- crit_valid_o  output  1  critical word valid, one-cycle pulse
- crit_data_o  output  BEAT_WIDTH  critical word
- busy_o  output  1  fill in progress
- done_o  output  1  fill complete, one-cycle pulse

Function
REQ-003 The FSM SHALL have states IDLE, FILL and WRITE.
REQ-004 In IDLE: req_ready_o=1 and mem_ready_o=0; on req_valid_i&&req_ready_o, latch req_idx_i and req_word_i, clear the beat counter, and go to FILL.
REQ-005 In FILL: mem_ready_o=1 and req_ready_o=0; each mem_valid_i&&mem_ready_o beat SHALL be written into line slot (start+cnt) mod 4, where slot k occupies bits [32k+31:32k], and cnt SHALL increment by 1.
REQ-006 The start slot SHALL be the latched req_word_i when L1_FILL_CRIT_WORD_EN is defined and 0 otherwise; the slot index SHALL wrap modulo 4.
REQ-007 Accepting the 4th beat (cnt==3) SHALL move the FSM to WRITE on the next edge; no further beats SHALL be accepted.
REQ-008 Gaps in mem_valid_i SHALL stall FILL indefinitely without losing or reordering beats.
REQ-009 For exactly one cycle in WRITE: dat_we_o=1, dat_be_o=16'hFFFF, dat_addr_o=latched index, dat_data_o=assembled line, done_o=1; the FSM SHALL then return to IDLE.
REQ-010 Outside WRITE: dat_we_o=0 and dat_be_o=0; dat_addr_o and dat_data_o SHALL hold their last values.
REQ-011 busy_o SHALL be 1 in FILL and WRITE and 0 in IDLE.
REQ-012 Latency: with a request accepted at edge N and gap-free beats at edges N+1..N+4, dat_we_o SHALL be high in cycle N+5.
REQ-013 A req_valid_i asserted while busy_o=1 SHALL be ignored (not latched) until IDLE.
REQ-014 mem_valid_i asserted in IDLE or WRITE SHALL be ignored.
REQ-015 All outputs SHALL be driven from registers, except req_ready_o and mem_ready_o, which SHALL be decoded from state.

Reset
REQ-016 When rst_ni is low, the block SHALL asynchronously go to IDLE and clear all of the following: the counter, the latched index and word, the line buffer, dat_*_o, crit_*_o, done_o and busy_o.
REQ-017 A reset during FILL or WRITE SHALL abandon the partial line with no array write; the first edge after release SHALL be IDLE.

Configuration
REQ-018 With L1_FILL_CRIT_WORD_EN defined, memory SHALL return beats critical-word-first from slot req_word_i, and the first accepted beat SHALL drive crit_valid_o=1 and crit_data_o=beat in the following cycle.
REQ-019 Without L1_FILL_CRIT_WORD_EN, beats SHALL fill slots 0,1,2,3 in order, and crit_valid_o and crit_data_o SHALL be constant 0.

Verification
REQ-020 Scenario: idx=6'h2A, word=0, beats 11111111,22222222,33333333,44444444 back-to-back -> one dat_we_o pulse at N+5, addr 2A, be FFFF, data 44444444_33333333_22222222_11111111, done_o same cycle.
REQ-021 Scenario (macro on): word=2, beats A,B,C,D -> slots 2,3,0,1, i.e. line {B,A,D,C} (slot 3 down to 0); crit_valid_o pulses once with data A.
REQ-022 Scenario: same as REQ-020 with 3 idle cycles before each of beats 2 and 4 -> identical line, write at N+11, busy_o high N+1..N+11.
REQ-023 Scenario: second req_valid_i held during a fill, plus spurious mem_valid_i in IDLE -> second request accepted only after done_o; no extra writes.
REQ-024 Scenario: rst_ni low after 2 beats -> no dat_we_o, outputs 0 at once; a new 4-beat fill then completes normally.
REQ-025 Scenario: idx=6'h3F, word=3, macro off -> slots 0..3 in order, addr 3F, crit_valid_o never asserted.
